// File: rtl/if_fetch_stage_if.sv
// Bundle between the LC-3b fetch stage and its neighbours: the downstream stall and
// redirect inputs, the instruction-memory request/response, and the IF/ID register controls.
interface if_fetch_stage_if;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        imem_read;
  logic [15:0] imem_address;
  logic        imem_resp;
  logic [15:0] imem_rdata;
  logic [15:0] if_pc;
  logic [15:0] if_instr;
  logic        if_load;
  logic        if_flush;

  modport master (
    input  stall, redirect, redirect_pc, imem_resp, imem_rdata,
    output imem_read, imem_address, if_pc, if_instr, if_load, if_flush
  );

  modport slave (
    output stall, redirect, redirect_pc, imem_resp, imem_rdata,
    input  imem_read, imem_address, if_pc, if_instr, if_load, if_flush
  );
endinterface

// File: rtl/if_fetch_stage.sv
// LC-3b instruction fetch stage: owns the PC, buffers one instruction across decode
// stalls, and drops in-flight data after redirects. Define IF_STALL_CNT_EN to add stall_cycles.
module if_fetch_stage #(
  parameter logic [15:0] PC_RESET = 16'h0000
) (
  input  logic              clk,
  input  logic              reset,
  if_fetch_stage_if.master  bus
`ifdef IF_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cycles
`endif
);

  typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] req_addr_q, req_addr_d;
  logic [15:0] hold_instr_q, hold_instr_d;

  logic        read_c;
  logic        load_c;
  logic [15:0] instr_c;
  logic [15:0] seq_addr;
  logic [15:0] redirect_tgt;

  assign seq_addr     = req_addr_q + 16'd2;
  assign redirect_tgt = {bus.redirect_pc[15:1], 1'b0};

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    hold_instr_d = hold_instr_q;
    read_c       = 1'b0;
    load_c       = 1'b0;
    instr_c      = hold_instr_q;

    unique case (state_q)
      FETCH: begin
        read_c  = 1'b1;
        instr_c = bus.imem_rdata;
        if (bus.redirect) begin
          pc_d = redirect_tgt;
          if (bus.imem_resp) req_addr_d = redirect_tgt;
          else               state_d    = DISCARD;
        end else if (bus.imem_resp) begin
          if (!bus.stall) begin
            load_c     = 1'b1;
            pc_d       = seq_addr;
            req_addr_d = seq_addr;
          end else begin
            hold_instr_d = bus.imem_rdata;
            state_d      = HOLD;
          end
        end
      end

      HOLD: begin
        if (bus.redirect) begin
          pc_d         = redirect_tgt;
          req_addr_d   = redirect_tgt;
          hold_instr_d = 16'h0000;
          state_d      = FETCH;
        end else if (!bus.stall) begin
          load_c     = 1'b1;
          pc_d       = seq_addr;
          req_addr_d = seq_addr;
          state_d    = FETCH;
        end
      end

      DISCARD: begin
        // Stale request must still complete; a redirect here only retargets pc.
        read_c = 1'b1;
        if (bus.redirect) begin
          pc_d = redirect_tgt;
          if (bus.imem_resp) begin
            req_addr_d = redirect_tgt;
            state_d    = FETCH;
          end
        end else if (bus.imem_resp) begin
          req_addr_d = pc_q;
          state_d    = FETCH;
        end
      end

      default: state_d = FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= FETCH;
      pc_q         <= PC_RESET;
      req_addr_q   <= PC_RESET;
      hold_instr_q <= 16'h0000;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      hold_instr_q <= hold_instr_d;
    end
  end

  // Reset state alone is FETCH, which would request; gate outputs so reset silences them.
  assign bus.imem_read    = read_c & ~reset;
  assign bus.imem_address = req_addr_q;
  assign bus.if_load      = load_c & ~bus.redirect & ~reset;
  assign bus.if_flush     = bus.redirect & ~reset;
  assign bus.if_instr     = reset ? 16'h0000 : instr_c;
  assign bus.if_pc        = reset ? 16'h0000 : seq_addr;

`ifdef IF_STALL_CNT_EN
  logic        idle_c;
  logic [15:0] stall_cnt_q;

  assign idle_c = (state_q != FETCH) || !bus.imem_resp;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                    stall_cnt_q <= 16'h0000;
    else if (idle_c && stall_cnt_q != 16'hFFFF)   stall_cnt_q <= stall_cnt_q + 16'd1;
  end

  assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: variable-latency memory model, a program-order reference
// model checking every load/flush, directed scenarios, then randomized stall/redirect traffic.
module tb_if_fetch_stage;
  logic clk = 1'b0;
  logic reset;

  if_fetch_stage_if bus ();

`ifdef IF_STALL_CNT_EN
  logic [15:0] stall_cycles;
`endif

  if_fetch_stage #(.PC_RESET(16'h0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef IF_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] memfn(input logic [15:0] a);
    return (a * 16'h1357) ^ 16'hC0DE;
  endfunction

  // Memory: answers in the lat-th cycle a request is presented (lat=1 answers same cycle).
  logic [2:0]  lat = 3'd1;
  logic [2:0]  mem_cnt;
  logic [15:0] mem_addr_q;

  always_comb begin
    bus.imem_resp  = bus.imem_read && (mem_cnt == lat - 3'd1);
    bus.imem_rdata = bus.imem_resp ? memfn(bus.imem_address) : 16'hDEAD;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_cnt    <= 3'd0;
      mem_addr_q <= 16'h0000;
    end else if (bus.imem_read) begin
      if (mem_cnt == 3'd0) mem_addr_q <= bus.imem_address;
      mem_cnt <= bus.imem_resp ? 3'd0 : mem_cnt + 3'd1;
    end
  end

  // Reference model: loads must follow program order from the last redirect target.
  logic [15:0] exp_next;
  int          loads_seen = 0;

  always @(negedge clk) begin
    if (reset) begin
      exp_next = 16'h0000;
    end else begin
      check("flush_vs_redirect", 16'(bus.if_flush), 16'(bus.redirect));
      if (bus.imem_read && mem_cnt != 3'd0)
        check("addr_stable", bus.imem_address, mem_addr_q);
      if (bus.redirect) begin
        check("load_on_redirect", 16'(bus.if_load), 16'h0);
        exp_next = {bus.redirect_pc[15:1], 1'b0};
      end else if (bus.stall) begin
        check("load_on_stall", 16'(bus.if_load), 16'h0);
      end else if (bus.if_load) begin
        check("mon_pc", bus.if_pc, exp_next + 16'd2);
        check("mon_instr", bus.if_instr, memfn(exp_next));
        exp_next = exp_next + 16'd2;
        loads_seen++;
      end
    end
  end

  task automatic nc();
    @(posedge clk);
    #1;
  endtask

  task automatic st();
    #3;
  endtask

  task automatic do_reset(input logic [2:0] l);
    reset           = 1'b1;
    bus.stall       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 16'h0000;
    lat             = l;
    nc();
    nc();
    reset = 1'b0;
  endtask

  initial begin
    int          start_loads;
    logic [15:0] a;

    reset           = 1'b1;
    bus.stall       = 1'b0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h1234;
    #12;
    check("rst_read",  16'(bus.imem_read), 16'h0);
    check("rst_load",  16'(bus.if_load),   16'h0);
    check("rst_flush", 16'(bus.if_flush),  16'h0);
    check("rst_instr", bus.if_instr,       16'h0);
    check("rst_pc",    bus.if_pc,          16'h0);
`ifdef IF_STALL_CNT_EN
    check("rst_stall_cnt", stall_cycles, 16'h0);
`endif

    // Single-cycle memory: back-to-back fetches with no bubbles.
    do_reset(3'd1);
    for (int i = 0; i < 4; i++) begin
      a = 16'(i * 2);
      st();
      check("b2b_addr",  bus.imem_address,  a);
      check("b2b_read",  16'(bus.imem_read), 16'h1);
      check("b2b_load",  16'(bus.if_load),   16'h1);
      check("b2b_pc",    bus.if_pc,          a + 16'd2);
      check("b2b_instr", bus.if_instr,       memfn(a));
      nc();
    end

    // Three-cycle memory latency.
    do_reset(3'd3);
    for (int i = 0; i < 3; i++) begin
      st();
      check("lat3_addr", bus.imem_address,  16'h0000);
      check("lat3_read", 16'(bus.imem_read), 16'h1);
      check("lat3_load", 16'(bus.if_load),   16'(i == 2));
      if (i == 2) begin
        check("lat3_instr", bus.if_instr, memfn(16'h0000));
        check("lat3_pc",    bus.if_pc,    16'h0002);
      end
      nc();
    end
    st();
    check("lat3_next_addr", bus.imem_address, 16'h0002);

    // Response at 4 during a two-cycle stall, then release.
    do_reset(3'd1);
    nc();
    nc();
    bus.stall = 1'b1;
    st();
    check("hold_resp_addr", bus.imem_address, 16'h0004);
    check("hold_resp_load", 16'(bus.if_load), 16'h0);
    nc();
    st();
    check("hold_read", 16'(bus.imem_read), 16'h0);
    check("hold_load", 16'(bus.if_load),   16'h0);
    nc();
    bus.stall = 1'b0;
    st();
    check("hold_rel_read",  16'(bus.imem_read), 16'h0);
    check("hold_rel_load",  16'(bus.if_load),   16'h1);
    check("hold_rel_instr", bus.if_instr,       memfn(16'h0004));
    check("hold_rel_pc",    bus.if_pc,          16'h0006);
    nc();
    st();
    check("hold_next_addr", bus.imem_address, 16'h0006);

    // Redirect while a slow request to 8 is outstanding.
    do_reset(3'd1);
    for (int i = 0; i < 4; i++) nc();
    lat             = 3'd3;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h3001;
    st();
    check("disc_flush", 16'(bus.if_flush), 16'h1);
    check("disc_load",  16'(bus.if_load),  16'h0);
    check("disc_addr",  bus.imem_address,  16'h0008);
    nc();
    bus.redirect = 1'b0;
    st();
    check("disc_flush_once", 16'(bus.if_flush), 16'h0);
    check("disc_stale_addr", bus.imem_address,  16'h0008);
    nc();
    st();
    check("disc_resp_resp", 16'(bus.imem_resp), 16'h1);
    check("disc_drop_load", 16'(bus.if_load),   16'h0);
    nc();
    st();
    check("disc_new_addr", bus.imem_address,  16'h3000);
    check("disc_new_read", 16'(bus.imem_read), 16'h1);
    nc();
    nc();
    st();
    check("disc_tgt_load",  16'(bus.if_load), 16'h1);
    check("disc_tgt_instr", bus.if_instr,     memfn(16'h3000));
    check("disc_tgt_pc",    bus.if_pc,        16'h3002);

    // Redirect and stall together while holding.
    do_reset(3'd1);
    bus.stall = 1'b1;
    st();
    check("rs_enter_load", 16'(bus.if_load), 16'h0);
    nc();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h1234;
    st();
    check("rs_flush", 16'(bus.if_flush),  16'h1);
    check("rs_load",  16'(bus.if_load),   16'h0);
    check("rs_read",  16'(bus.imem_read), 16'h0);
    nc();
    bus.redirect = 1'b0;
    bus.stall    = 1'b0;
    st();
    check("rs_addr",  bus.imem_address, 16'h1234);
    check("rs_load2", 16'(bus.if_load), 16'h1);
    check("rs_instr", bus.if_instr,     memfn(16'h1234));
    check("rs_pc",    bus.if_pc,        16'h1236);

    // Redirect with same-cycle response into the top of memory, then wrap.
    do_reset(3'd1);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'hFFFF;
    st();
    check("wrap_flush", 16'(bus.if_flush), 16'h1);
    check("wrap_drop",  16'(bus.if_load),  16'h0);
    nc();
    bus.redirect = 1'b0;
    st();
    check("wrap_addr",  bus.imem_address, 16'hFFFE);
    check("wrap_load",  16'(bus.if_load), 16'h1);
    check("wrap_pc",    bus.if_pc,        16'h0000);
    check("wrap_instr", bus.if_instr,     memfn(16'hFFFE));
    nc();
    st();
    check("wrap_next_addr", bus.imem_address, 16'h0000);

`ifdef IF_STALL_CNT_EN
    do_reset(3'd5);
    st();
    check("cnt_start", stall_cycles, 16'h0000);
    for (int i = 0; i < 4; i++) nc();
    st();
    check("cnt_four", stall_cycles, 16'h0004);
`endif

    // Randomized traffic checked by the reference model.
    do_reset(3'd1);
    start_loads = loads_seen;
    for (int i = 0; i < 2000; i++) begin
      nc();
      bus.stall       = ($urandom % 10) < 3;
      bus.redirect    = ($urandom % 20) == 0;
      bus.redirect_pc = 16'($urandom);
      if (mem_cnt == 3'd0) lat = 3'($urandom_range(1, 4));
    end
    st();
    check("rand_progress", 16'((loads_seen - start_loads) >= 100), 16'h1);

    // Asynchronous reset mid-cycle silences outputs immediately.
    nc();
    bus.stall    = 1'b0;
    bus.redirect = 1'b0;
    lat          = 3'd3;
    nc();
    reset = 1'b1;
    #1;
    check("async_rst_read",  16'(bus.imem_read), 16'h0);
    check("async_rst_load",  16'(bus.if_load),   16'h0);
    check("async_rst_pc",    bus.if_pc,          16'h0);
    check("async_rst_instr", bus.if_instr,       16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
LC-3b instruction fetch stage. It sits directly upstream of the IF/ID pipeline register.
- Owns the PC and issues read requests to instruction memory.
- Buffers a returned instruction while decode stalls.
- Takes branch/jump redirects from later stages.
- Drives the load and flush controls, plus the pc and instr data, of the IF/ID register.

Parameters:
PC_RESET, 16'h0000, PC value loaded on reset (bit 0 must be 0)

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-high; all state cleared immediately
stall  in  1  downstream cannot accept an instruction this cycle
redirect  in  1  taken branch/jump/trap from a later stage
redirect_pc  in  16  redirect target; bit 0 ignored and forced to 0
imem_read  out  1  instruction memory read request
imem_address  out  16  request address, stable while imem_read=1
imem_resp  in  1  one-cycle response strobe
imem_rdata  in  16  read data, valid only when imem_resp=1
if_pc  out  16  address of the fetched instruction + 2 (LC-3b incremented PC)
if_instr  out  16  fetched instruction
if_load  out  1  load strobe for the IF/ID register
if_flush  out  1  flush (reset) strobe for the IF/ID register

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, named reset.
- While reset=1:
  - pc=PC_RESET, state=FETCH, hold buffer=0.
  - Outputs forced: imem_read=0, if_load=0, if_flush=0, if_instr=0, if_pc=0.
- Registers: pc (next fetch address), req_addr (address of the outstanding request), hold_instr, state.
- Memory contract:
  - While imem_read=1, imem_address must not change until the imem_resp cycle.
  - No aborts; exactly one imem_resp per request.
- PC arithmetic: 16-bit, +2, wraps (16'hFFFE+2 = 16'h0000).
- State FETCH:
  - imem_read=1, imem_address=req_addr (= pc on entry).
  - No resp: hold.
  - resp, stall=0: if_load=1 combinationally in the resp cycle; if_instr=imem_rdata; if_pc=req_addr+2. Next cycle: pc, req_addr <= req_addr+2; stay in FETCH. Zero-bubble back-to-back fetch when resp comes in one cycle.
  - resp, stall=1: hold_instr <= imem_rdata; go to HOLD.
- State HOLD:
  - imem_read=0; if_instr=hold_instr; if_pc=req_addr+2.
  - if_load = !stall.
  - When stall=0: pc, req_addr <= req_addr+2; go to FETCH.
- State DISCARD:
  - imem_read=1 at the stale req_addr; if_load=0.
  - On resp: data dropped; req_addr <= pc; go to FETCH.
- Redirect (highest priority, any state):
  - Same cycle: if_flush=1, if_load=0.
  - Next cycle: pc <= {redirect_pc[15:1],0}.
  - FETCH with no resp this cycle: go to DISCARD. req_addr is unchanged so the outstanding request completes.
  - FETCH with resp this cycle: data dropped; req_addr <= new pc; stay in FETCH.
  - HOLD: hold_instr dropped; req_addr <= new pc; go to FETCH.
  - DISCARD: pc updated; stay in DISCARD.
- Simultaneous redirect and stall: redirect wins; the flush is issued regardless of stall.
- Reset mid-transaction: the request is abandoned, and the memory model must be reset with the same signal.
- if_pc/if_instr are don't-care when if_load=0, except during reset (0).

Optional Feature:
- Macro: IF_STALL_CNT_EN.
- Defined:
  - Adds output stall_cycles [15:0].
  - Increments each cycle the stage is in FETCH without resp, in HOLD, or in DISCARD.
  - Saturates at 16'hFFFF; reset to 0 by reset.
- Undefined: the port and counter are absent; functional behaviour is identical.

Test Plan:
- Reset release, PC_RESET=0, memory answering every cycle: imem_address 0,2,4,6 on consecutive cycles; if_load=1 each cycle; if_pc 2,4,6,8.
- Memory with 3-cycle latency, stall=0: imem_address=0 held 3 cycles; single if_load with if_instr=mem[0], if_pc=2; then address=2.
- resp at address 4 while stall=1 for 2 cycles: imem_read=0 during HOLD; if_load=1 in the first stall=0 cycle with the buffered instr and if_pc=6; next fetch address=6.
- redirect to 16'h3001 while a 3-cycle request to 8 is outstanding: if_flush=1 for one cycle; the request to 8 completes and its data is dropped (no if_load); next request to 16'h3000.
- redirect and stall asserted together in HOLD: if_flush=1, if_load=0; next fetch from the redirect target.
- pc at 16'hFFFE fetched: if_pc=0; next imem_address=0. With IF_STALL_CNT_EN, 4 stalled cycles produce stall_cycles=4.
